ama_riscv_mem_arb: RTL and testbench
====================================

AMA_RISCV_MEM_ARB -- requirements
Module: ama_riscv_mem_arb

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, backing-memory beat address width.
REQ-002 The block SHALL have parameter DATA_W, default 128, beat data width.
REQ-003 The block SHALL have parameter BEATS, default 4, response beats per read (cache line = BEATS*DATA_W).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port rst, input, 1, synchronous active-low reset.
REQ-006 The block SHALL have port req_valid, input, [1:0], request valid; index 0 = d$, 1 = i$.
REQ-007 The block SHALL have port req_ready, output, [1:0], request accepted this cycle.
REQ-008 The block SHALL have port req_addr, input, [1:0][ADDR_W], line address per requester.
REQ-009 The block SHALL have port req_we, input, [1:0], write request (i$ index tied 0 by integrator).
REQ-010 The block SHALL have port req_wdata, input, [1:0][DATA_W], write data (single beat).
REQ-011 The block SHALL have port rsp_valid, output, [1:0], response beat valid to the granted requester.
REQ-012 The block SHALL have port rsp_last, output, [1:0], final beat of the transaction.
REQ-013 The block SHALL have port rsp_data, output, DATA_W, response data broadcast to both requesters.
REQ-014 The block SHALL have ports mem_req_valid (output, 1), mem_req_ready (input, 1), mem_req_addr (output, ADDR_W), mem_req_we (output, 1) and mem_req_wdata (output, DATA_W), forming the backing-memory request channel.
REQ-015 The block SHALL have ports mem_rsp_valid (input, 1) and mem_rsp_data (input, DATA_W), forming the backing-memory response channel with no backpressure.
REQ-016 The block SHALL have port err_unexp_rsp, output, 1, sticky flag for a response beat arriving outside RSP.

Function
REQ-017 The FSM SHALL have states IDLE, REQ and RSP; only one transaction is outstanding at a time.
REQ-018 In IDLE with any req_valid, the block SHALL pick a winner, assert req_ready[winner] combinationally in the same cycle, latch addr/we/wdata/grant, and go to REQ.
REQ-019 Arbitration SHALL be round-robin: on simultaneous valids the requester not granted last wins; a lone valid always wins.
REQ-020 After reset the round-robin pointer SHALL favour d$ (index 0).
REQ-021 In REQ the block SHALL hold mem_req_valid=1 with latched fields stable until mem_req_ready, then go to RSP with beat_cnt=0.
REQ-022 In RSP, each mem_rsp_valid SHALL produce rsp_valid[grant]=1 and rsp_data=mem_rsp_data in the same cycle (combinational pass-through).
REQ-023 On a read, rsp_last SHALL assert on the beat where beat_cnt==BEATS-1; on a write, the single ack beat SHALL carry rsp_last.
REQ-024 On the last beat the block SHALL return to IDLE and update the pointer, so at least one IDLE cycle separates transactions.
REQ-025 beat_cnt SHALL be $clog2(BEATS) bits wide (minimum 1) and SHALL clear on entry to RSP, never wrapping within a transaction.
REQ-026 mem_rsp_valid in IDLE or REQ SHALL be dropped (no rsp_valid) and SHALL set err_unexp_rsp.
REQ-027 req_ready SHALL be 0 in REQ and RSP; requesters hold req_valid and their fields until accepted.
REQ-028 rsp_valid for the non-granted index SHALL always be 0.
REQ-029 Minimum latency SHALL be: accept at cycle N, mem_req_valid at N+1, first response no earlier than N+2.

Reset
REQ-030 While rst=0, at the clock edge the block SHALL enter IDLE, clear beat_cnt, point round-robin to d$, and clear err_unexp_rsp and latched fields.
REQ-031 During and after reset, outputs SHALL be req_ready=0, rsp_valid=0, rsp_last=0, rsp_data=mem_rsp_data (don't-care), mem_req_valid=0, mem_req_we=0, mem_req_addr=0 and mem_req_wdata=0.
REQ-032 A reset asserted mid-transaction SHALL abandon it; later beats of that transaction SHALL be treated per REQ-026.

Structure
REQ-033 The types arb_state_t (IDLE/REQ/RSP), arb_idx_t (ARB_DC=0, ARB_IC=1) and the default BEATS constant SHALL live in the shared defines package.
REQ-034 Round-robin selection SHALL be a sub-module ama_riscv_arb_rr2 (two-input picker with pointer register and update enable).

Verification
REQ-035 The bench SHALL cover a lone i$ read at addr 0x0040 with mem_req_ready on the first cycle, expecting mem_req_addr=0x0040 at N+1, 4 rsp_valid[1] beats, and rsp_last only on the 4th.
REQ-036 The bench SHALL cover both valids in the first cycle after reset, expecting d$ granted first, i$ granted on the next IDLE, then d$ winning again on a further tie.
REQ-037 The bench SHALL cover a d$ write at addr 0x1234 with wdata 0xA5.., expecting mem_req_we=1 and the single ack beat to give rsp_valid[0]=1 with rsp_last[0]=1.
REQ-038 The bench SHALL hold mem_req_ready low for 5 cycles, expecting mem_req_valid and fields stable throughout and req_ready=0.
REQ-039 The bench SHALL inject mem_rsp_valid while in IDLE, expecting no rsp_valid and err_unexp_rsp=1 until reset.
REQ-040 The bench SHALL assert rst=0 after 2 of 4 read beats, expecting IDLE, all outputs at reset values, and the remaining beats dropped with the error flag set.

Source files
------------

// File: rtl/ama_riscv_mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter.
//   ARB_BEATS   : default number of response beats per cache-line read
//   arb_state_t : arbiter FSM states
//   arb_idx_t   : requester index (d$ = 0, i$ = 1)
package ama_riscv_mem_arb_pkg;

  localparam int unsigned ARB_BEATS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_DC = 1'b0,
    ARB_IC = 1'b1
  } arb_idx_t;

endpackage

// File: rtl/ama_riscv_arb_rr2.sv
// Two-input round-robin picker.
//   clk, rst    : clock, synchronous active-low reset
//   valid_i     : request valid per input
//   upd_i       : record upd_idx_i as the most recent winner
//   upd_idx_i   : winner to record
//   gnt_o       : combinational pick (meaningful when any_o)
//   any_o       : at least one input valid
module ama_riscv_arb_rr2
  import ama_riscv_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid_i,
  input  logic       upd_i,
  input  arb_idx_t   upd_idx_i,
  output arb_idx_t   gnt_o,
  output logic       any_o
);

  // Index that wins a tie; always the one not granted most recently.
  arb_idx_t prio_q;

  always_comb begin
    any_o = |valid_i;
    gnt_o = prio_q;
    if (valid_i == 2'b01) begin
      gnt_o = ARB_DC;
    end else if (valid_i == 2'b10) begin
      gnt_o = ARB_IC;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prio_q <= ARB_DC;
    end else if (upd_i) begin
      prio_q <= (upd_idx_i == ARB_DC) ? ARB_IC : ARB_DC;
    end
  end

endmodule

// File: rtl/ama_riscv_mem_arb.sv
// Arbitrates d$ (index 0) and i$ (index 1) onto a single backing-memory port.
// One transaction outstanding at a time: IDLE accepts, REQ presents the
// request to memory, RSP forwards BEATS read beats (or one write ack).
//   clk, rst            : clock, synchronous active-low reset
//   req_*               : per-requester request channel (valid/ready/addr/we/wdata)
//   rsp_valid/rsp_last  : per-requester response strobes; rsp_data broadcast
//   mem_req_*           : backing-memory request channel
//   mem_rsp_*           : backing-memory response channel, no backpressure
//   err_unexp_rsp       : sticky, a memory beat arrived outside RSP
module ama_riscv_mem_arb
  import ama_riscv_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned BEATS  = ARB_BEATS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0]             req_we,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  output logic [1:0]             rsp_valid,
  output logic [1:0]             rsp_last,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_W-1:0]      mem_req_addr,
  output logic                   mem_req_we,
  output logic [DATA_W-1:0]      mem_req_wdata,
  input  logic                   mem_rsp_valid,
  input  logic [DATA_W-1:0]      mem_rsp_data,
  output logic                   err_unexp_rsp
);

  localparam int unsigned BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);

  arb_state_t        state_q, state_d;
  logic [BCNT_W-1:0] beat_q, beat_d;
  arb_idx_t          grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;

  arb_idx_t arb_gnt;
  logic     arb_any;
  logic     arb_upd;
  logic     is_last;

  ama_riscv_arb_rr2 u_rr2 (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (req_valid),
    .upd_i     (arb_upd),
    .upd_idx_i (grant_q),
    .gnt_o     (arb_gnt),
    .any_o     (arb_any)
  );

  // A write completes with a single ack beat.
  assign is_last = we_q || (beat_q == LAST_BEAT);

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    grant_d       = grant_q;
    addr_d        = addr_q;
    we_d          = we_q;
    wdata_d       = wdata_q;
    err_d         = err_q;
    req_ready     = '0;
    rsp_valid     = '0;
    rsp_last      = '0;
    mem_req_valid = 1'b0;
    arb_upd       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          req_ready[arb_gnt] = 1'b1;
          grant_d            = arb_gnt;
          addr_d             = req_addr[arb_gnt];
          we_d               = req_we[arb_gnt];
          wdata_d            = req_wdata[arb_gnt];
          state_d            = REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = RSP;
          beat_d  = '0;
        end
      end
      RSP: begin
        if (mem_rsp_valid) begin
          rsp_valid[grant_q] = 1'b1;
          rsp_last[grant_q]  = is_last;
          if (is_last) begin
            state_d = IDLE;
            arb_upd = 1'b1;
          end else begin
            beat_d = beat_q + BCNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Beats outside RSP are dropped and flagged.
    if (mem_rsp_valid && (state_q != RSP)) begin
      err_d = 1'b1;
    end

    // Hold all handshakes quiet while reset is asserted.
    if (!rst) begin
      req_ready     = '0;
      rsp_valid     = '0;
      rsp_last      = '0;
      mem_req_valid = 1'b0;
      arb_upd       = 1'b0;
    end
  end

  assign rsp_data      = mem_rsp_data;
  assign mem_req_addr  = rst ? addr_q : '0;
  assign mem_req_we    = rst & we_q;
  assign mem_req_wdata = rst ? wdata_q : '0;
  assign err_unexp_rsp = err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      grant_q <= ARB_DC;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_ama_riscv_mem_arb.sv
module tb_ama_riscv_mem_arb;

  localparam int AW = 16;
  localparam int DW = 128;
  localparam int NB = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0][AW-1:0]  req_addr;
  logic [1:0]          req_we;
  logic [1:0][DW-1:0]  req_wdata;
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_last;
  logic [DW-1:0]       rsp_data;
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [AW-1:0]       mem_req_addr;
  logic                mem_req_we;
  logic [DW-1:0]       mem_req_wdata;
  logic                mem_rsp_valid;
  logic [DW-1:0]       mem_rsp_data;
  logic                err_unexp_rsp;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ama_riscv_mem_arb #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .BEATS  (NB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_we        (req_we),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_last      (rsp_last),
    .rsp_data      (rsp_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_we    (mem_req_we),
    .mem_req_wdata (mem_req_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .err_unexp_rsp (err_unexp_rsp)
  );

  typedef struct {
    logic [1:0]    v;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic          we0;
    logic [DW-1:0] wd0;
    int            gnt;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".req_ready"}, DW'(req_ready), '0);
    chk({tag, ".rsp_valid"}, DW'(rsp_valid), '0);
    chk({tag, ".rsp_last"}, DW'(rsp_last), '0);
    chk({tag, ".mem_req_valid"}, DW'(mem_req_valid), '0);
    chk({tag, ".mem_req_we"}, DW'(mem_req_we), '0);
    chk({tag, ".mem_req_addr"}, DW'(mem_req_addr), '0);
    chk({tag, ".mem_req_wdata"}, mem_req_wdata, '0);
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    req_valid     = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // One complete transaction. gnt is the bench's expected winner; the loser's
  // valid (if any) stays asserted throughout, as a real requester would.
  task automatic run_txn(input logic [1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic we0, input logic [DW-1:0] wd0, input int gnt,
                         input int stall, input int gap, input string tag);
    logic [AW-1:0] ea;
    logic          ewe;
    logic [DW-1:0] ewd;
    logic [DW-1:0] d;
    logic [1:0]    mask;
    int            nb;
    mask = 2'b01 << gnt;
    ea   = (gnt == 1) ? a1 : a0;
    ewe  = (gnt == 0) && we0;
    ewd  = (gnt == 1) ? '0 : wd0;
    nb   = ewe ? 1 : NB;
    req_valid    = v;
    req_addr[0]  = a0;
    req_addr[1]  = a1;
    req_we       = {1'b0, we0};
    req_wdata[0] = wd0;
    req_wdata[1] = '0;
    #1;
    chk({tag, ".accept"}, DW'(req_ready), DW'(mask));
    step();
    req_valid[gnt] = 1'b0;
    for (int s = 0; s <= stall; s++) begin
      mem_req_ready = (s == stall);
      #1;
      chk({tag, ".mem_req_valid"}, DW'(mem_req_valid), 1);
      chk({tag, ".mem_req_addr"}, DW'(mem_req_addr), DW'(ea));
      chk({tag, ".mem_req_we"}, DW'(mem_req_we), DW'(ewe));
      chk({tag, ".mem_req_wdata"}, mem_req_wdata, ewd);
      chk({tag, ".req_ready_busy"}, DW'(req_ready), '0);
      step();
    end
    mem_req_ready = 1'b0;
    for (int b = 0; b < nb; b++) begin
      for (int g = 0; g < gap; g++) begin
        mem_rsp_valid = 1'b0;
        #1;
        chk({tag, ".rsp_gap"}, DW'(rsp_valid), '0);
        step();
      end
      d = {$urandom, $urandom, $urandom, $urandom};
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = d;
      #1;
      chk({tag, ".rsp_valid"}, DW'(rsp_valid), DW'(mask));
      chk({tag, ".rsp_last"}, DW'(rsp_last), (b == nb - 1) ? DW'(mask) : '0);
      chk({tag, ".rsp_data"}, rsp_data, d);
      chk({tag, ".req_ready_rsp"}, DW'(req_ready), '0);
      step();
    end
    mem_rsp_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    pend;
    logic [AW-1:0] ra [2];
    logic          rwe;
    logic [DW-1:0] rwd;
    int            last_gnt;
    int            g;

    tbl[0] = '{v: 2'b11, a0: 16'h0010, a1: 16'h0020, we0: 1'b0, wd0: '0, gnt: 0};
    tbl[1] = '{v: 2'b11, a0: 16'h0011, a1: 16'h0020, we0: 1'b0, wd0: '0, gnt: 1};
    tbl[2] = '{v: 2'b11, a0: 16'h0011, a1: 16'h0021, we0: 1'b0, wd0: '0, gnt: 0};
    tbl[3] = '{v: 2'b10, a0: 16'h0000, a1: 16'h0040, we0: 1'b0, wd0: '0, gnt: 1};
    tbl[4] = '{v: 2'b01, a0: 16'h1234, a1: 16'h0000, we0: 1'b1, wd0: {16{8'hA5}}, gnt: 0};
    tbl[5] = '{v: 2'b01, a0: 16'h0300, a1: 16'h0000, we0: 1'b0, wd0: '0, gnt: 0};

    rst           = 1'b0;
    req_valid     = 2'b11;
    req_addr[0]   = 16'hBEEF;
    req_addr[1]   = 16'hCAFE;
    req_we        = 2'b01;
    req_wdata     = '1;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    #1;
    chk_quiet("in_reset");
    step();
    step();
    chk_quiet("reset_held");
    chk("reset.err", DW'(err_unexp_rsp), '0);
    req_valid     = '0;
    mem_req_ready = 1'b0;
    rst           = 1'b1;
    #1;
    chk_quiet("after_reset");

    // Table: tie sequence right after reset, lone i$ read, d$ write, lone d$.
    for (int i = 0; i < 6; i++) begin
      run_txn(tbl[i].v, tbl[i].a0, tbl[i].a1, tbl[i].we0, tbl[i].wd0, tbl[i].gnt, 0, 0,
              $sformatf("tbl%0d", i));
    end
    chk("tbl.err", DW'(err_unexp_rsp), '0);

    // Memory stalls five cycles; last grant was d$ so the tie goes to i$.
    run_txn(2'b11, 16'h0500, 16'h0600, 1'b0, '0, 1, 5, 0, "stall");

    // Unexpected beat in IDLE.
    req_valid     = '0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = {4{32'h1357_9BDF}};
    #1;
    chk("unexp.rsp_valid", DW'(rsp_valid), '0);
    step();
    mem_rsp_valid = 1'b0;
    #1;
    chk("unexp.err", DW'(err_unexp_rsp), 1);
    step();
    step();
    step();
    chk("unexp.err_sticky", DW'(err_unexp_rsp), 1);
    do_reset();
    #1;
    chk("unexp.err_cleared", DW'(err_unexp_rsp), '0);

    // Reset after two of four read beats.
    req_valid   = 2'b01;
    req_addr[0] = 16'h0200;
    req_we      = '0;
    #1;
    chk("midrst.accept", DW'(req_ready), 1);
    step();
    req_valid     = '0;
    mem_req_ready = 1'b1;
    #1;
    chk("midrst.mem_req_valid", DW'(mem_req_valid), 1);
    step();
    mem_req_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_rsp_valid = 1'b1;
      #1;
      chk("midrst.beat", DW'(rsp_valid), 1);
      step();
    end
    rst           = 1'b0;
    mem_rsp_valid = 1'b0;
    req_valid     = 2'b11;
    #1;
    chk_quiet("midrst.during");
    step();
    rst       = 1'b1;
    req_valid = '0;
    #1;
    chk_quiet("midrst.after");
    for (int b = 0; b < 2; b++) begin
      mem_rsp_valid = 1'b1;
      #1;
      chk("midrst.dropped", DW'(rsp_valid), '0);
      chk("midrst.dropped_last", DW'(rsp_last), '0);
      step();
    end
    mem_rsp_valid = 1'b0;
    #1;
    chk("midrst.err", DW'(err_unexp_rsp), 1);
    req_valid = 2'b10;
    #1;
    chk("midrst.idle_accept", DW'(req_ready), 2);
    req_valid = '0;
    do_reset();

    // Randomised traffic against a request-level model: a tie goes to the
    // requester that was not served last (d$ after reset), a lone request wins.
    pend     = '0;
    last_gnt = 1;
    ra[0]    = '0;
    ra[1]    = '0;
    rwe      = 1'b0;
    rwd      = '0;
    for (int n = 0; n < 40; n++) begin
      if (!pend[0] && ($urandom_range(0, 1) == 1)) begin
        pend[0] = 1'b1;
        ra[0]   = AW'($urandom);
        rwe     = 1'($urandom_range(0, 1));
        rwd     = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!pend[1] && ($urandom_range(0, 1) == 1)) begin
        pend[1] = 1'b1;
        ra[1]   = AW'($urandom);
      end
      if (pend == 2'b00) begin
        pend[1] = 1'b1;
        ra[1]   = AW'($urandom);
      end
      if (pend == 2'b11) g = 1 - last_gnt;
      else g = pend[1] ? 1 : 0;
      run_txn(pend, ra[0], ra[1], rwe, rwd, g, $urandom_range(0, 3), $urandom_range(0, 2),
              $sformatf("rnd%0d", n));
      pend[g]  = 1'b0;
      last_gnt = g;
    end
    req_valid = '0;
    #1;
    chk("rnd.err", DW'(err_unexp_rsp), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
